uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Consumes bytes from the UART receiver through its `dataAvailable`/`readFlag`/`receivedData` interface.
- Assembles fixed-length command frames and checks the XOR checksum.
- Presents each valid command to the processor/debug logic as a one-cycle strobe.
- Answers every completed frame with an ACK or NAK byte through the UART transmitter's `dataToSend`/`uart_tx_start`/`uart_tx_done` handshake.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- ACK_BYTE, 8'h06, response to a good frame.
- NAK_BYTE, 8'h15, response to a checksum failure.
- DATA_BYTES, 4, payload bytes per frame, MSB first; cmd_data width = 8*DATA_BYTES.
- TIMEOUT_CYCLES, 65000, maximum clk cycles between accepted bytes inside a frame (about 10 byte times at 19200 baud, 12.5 MHz).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- uart_reset  in  1  synchronous, active-high reset.
- dataAvailable  in  1  UART receiver holds a byte.
- receivedData  in  8  byte from the UART receiver.
- readFlag  out  1  one-cycle pulse that consumes the current received byte.
- dataToSend  out  8  response byte; stable from the start pulse until done.
- uart_tx_start  out  1  one-cycle pulse that launches the response byte.
- uart_tx_done  in  1  transmitter finished the byte.
- cmd_valid  out  1  one-cycle strobe for a valid command.
- cmd_code  out  8  command byte; held until the next cmd_valid.
- cmd_data  out  8*DATA_BYTES  payload; held until the next cmd_valid.
- frame_error  out  1  one-cycle pulse on checksum failure or timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - readFlag, uart_tx_start, cmd_valid, frame_error, busy = 0.
  - dataToSend, cmd_code, cmd_data = 0.
  - Byte counter, checksum and timeout counter = 0.
- Reset mid-operation: any state, including RESP_WAIT, returns to IDLE on the next edge. A pending uart_tx_start is dropped; an already started transmission is not tracked.
- Byte intake, used in IDLE, CMD, DATA and CSUM:
  - When dataAvailable=1 and rd_lock=0, latch receivedData, pulse readFlag for one cycle and set rd_lock.
  - rd_lock clears only when dataAvailable is sampled 0.
  - Holding dataAvailable high for many cycles therefore consumes exactly one byte.
  - Latency from dataAvailable to readFlag is one cycle.
- State machine:
  - IDLE: accepted byte == SOF_BYTE -> CMD, clear checksum and timeout. Any other byte is dropped silently, state stays IDLE.
  - CMD: accepted byte -> cmd_code shadow register, checksum = byte, byte counter = 0 -> DATA.
  - DATA: each accepted byte shifts into the payload shadow register (MSB first) and XORs into the checksum. After DATA_BYTES bytes -> CSUM.
  - CSUM: if accepted byte == checksum, copy the shadows to cmd_code/cmd_data, pulse cmd_valid, dataToSend = ACK_BYTE. Otherwise pulse frame_error, dataToSend = NAK_BYTE, leave the outputs unchanged. Either way -> RESP_START.
  - RESP_START: pulse uart_tx_start for one cycle -> RESP_WAIT.
  - RESP_WAIT: on uart_tx_done=1 -> IDLE. A done pulse in the same cycle as uart_tx_start is ignored.
- Bytes arriving during RESP_START/RESP_WAIT are left in the receiver (no readFlag) and handled from IDLE.
- Timeout:
  - In CMD/DATA/CSUM the counter increments every cycle and clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES -> pulse frame_error, go to IDLE, send no response.
- A SOF byte inside a frame is treated as ordinary data; there is no resynchronisation.
- Counter widths: timeout counter is $clog2(TIMEOUT_CYCLES+1) bits; byte counter is $clog2(DATA_BYTES+1) bits.
- busy = (state != IDLE), registered.

Decomposition:
- Package uart_cmd_pkg: state enum (IDLE, CMD, DATA, CSUM, RESP_START, RESP_WAIT) and default constants SOF/ACK/NAK.
- One natural sub-module: uart_byte_reader. It contains the dataAvailable/readFlag/rd_lock handshake and outputs byte_valid/byte_data to the parser FSM.
- The timeout counter stays inline.

Test Plan:
- Good frame: A5 01 12 34 56 78 09 -> one cmd_valid, cmd_code=0x01, cmd_data=0x12345678; uart_tx_start with dataToSend=0x06; after uart_tx_done, busy=0.
- Bad checksum: A5 01 12 34 56 78 00 -> no cmd_valid, frame_error pulse, dataToSend=0x15, cmd_data keeps its previous value.
- Leading garbage: 00 FF 3C, then the good frame -> the three bytes are each consumed by one readFlag and ignored; the frame decodes exactly as in the good-frame case.
- Slow receiver clear: dataAvailable held high 20 cycles per byte -> exactly one readFlag per byte; good frame still decodes.
- Timeout: A5 01 12, then silence for TIMEOUT_CYCLES -> frame_error pulse, state IDLE, no uart_tx_start; a following good frame decodes.
- Reset mid-frame: uart_reset asserted after A5 01 34 -> all outputs at reset values next cycle; a following good frame decodes correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and default constants for the UART command parser.
// The frame layout is SOF, command byte, payload (MSB first), then the XOR checksum.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CMD        = 3'd1,
        DATA       = 3'd2,
        CSUM       = 3'd3,
        RESP_START = 3'd4,
        RESP_WAIT  = 3'd5
    } state_t;

    localparam logic [7:0] SOF_DEFAULT        = 8'hA5;
    localparam logic [7:0] ACK_DEFAULT        = 8'h06;
    localparam logic [7:0] NAK_DEFAULT        = 8'h15;
    localparam int         DATA_BYTES_DEFAULT = 4;
    localparam int         TIMEOUT_DEFAULT    = 65000;

endpackage

// File: rtl/uart_byte_reader.sv
// Takes one byte per dataAvailable assertion from the UART receiver.
// rd_lock blocks re-reading the same byte until dataAvailable is seen low.
module uart_byte_reader (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       dataAvailable,
    input  logic [7:0] receivedData,
    output logic       readFlag,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic rd_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            readFlag  <= 1'b0;
            rd_lock   <= 1'b0;
            byte_data <= 8'h00;
        end else begin
            readFlag <= 1'b0;
            if (!dataAvailable) begin
                rd_lock <= 1'b0;
            end else if (enable && !rd_lock) begin
                readFlag  <= 1'b1;
                rd_lock   <= 1'b1;
                byte_data <= receivedData;
            end
        end
    end

    // The byte is handed to the parser in the same cycle it is acknowledged.
    assign byte_valid = readFlag;

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SOF/cmd/payload/checksum frames from the UART receiver, strobes valid
// commands out and answers each completed frame with ACK or NAK via the transmitter.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT,
    parameter int         DATA_BYTES     = DATA_BYTES_DEFAULT,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    uart_reset,
    input  logic                    dataAvailable,
    input  logic [7:0]              receivedData,
    output logic                    readFlag,
    output logic [7:0]              dataToSend,
    output logic                    uart_tx_start,
    input  logic                    uart_tx_done,
    output logic                    cmd_valid,
    output logic [7:0]              cmd_code,
    output logic [8*DATA_BYTES-1:0] cmd_data,
    output logic                    frame_error,
    output logic                    busy,
    output logic [2:0]              fsm_state
);

    localparam int DW    = 8 * DATA_BYTES;
    localparam int CNT_W = $clog2(DATA_BYTES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_t           state, state_n;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_n;
    logic [7:0]       csum, csum_n;
    logic [TO_W-1:0]  to_cnt, to_cnt_n;
    logic [7:0]       code_sh, code_sh_n;
    logic [DW-1:0]    data_sh, data_sh_n;
    logic [7:0]       cmd_code_n, tx_byte_n;
    logic [DW-1:0]    cmd_data_n;
    logic             cmd_valid_n, frame_error_n, tx_start_n;
    logic             in_frame, rd_en, byte_valid;
    logic [7:0]       byte_data;

    assign in_frame  = (state == CMD) || (state == DATA) || (state == CSUM);
    assign rd_en     = in_frame || (state == IDLE);
    assign fsm_state = state;

    uart_byte_reader u_reader (
        .clk          (clk),
        .rst          (uart_reset),
        .enable       (rd_en),
        .dataAvailable(dataAvailable),
        .receivedData (receivedData),
        .readFlag     (readFlag),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data)
    );

    always_ff @(posedge clk) begin
        if (uart_reset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            csum          <= 8'h00;
            to_cnt        <= '0;
            code_sh       <= 8'h00;
            data_sh       <= '0;
            cmd_code      <= 8'h00;
            cmd_data      <= '0;
            dataToSend    <= 8'h00;
            cmd_valid     <= 1'b0;
            frame_error   <= 1'b0;
            uart_tx_start <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            byte_cnt      <= byte_cnt_n;
            csum          <= csum_n;
            to_cnt        <= to_cnt_n;
            code_sh       <= code_sh_n;
            data_sh       <= data_sh_n;
            cmd_code      <= cmd_code_n;
            cmd_data      <= cmd_data_n;
            dataToSend    <= tx_byte_n;
            cmd_valid     <= cmd_valid_n;
            frame_error   <= frame_error_n;
            uart_tx_start <= tx_start_n;
            busy          <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n       = state;
        byte_cnt_n    = byte_cnt;
        csum_n        = csum;
        to_cnt_n      = to_cnt;
        code_sh_n     = code_sh;
        data_sh_n     = data_sh;
        cmd_code_n    = cmd_code;
        cmd_data_n    = cmd_data;
        tx_byte_n     = dataToSend;
        cmd_valid_n   = 1'b0;
        frame_error_n = 1'b0;
        tx_start_n    = 1'b0;

        // Inter-byte watchdog; an accepted byte always wins over an expiring count.
        if (in_frame) begin
            if (byte_valid) begin
                to_cnt_n = '0;
            end else if (to_cnt == TO_LIMIT) begin
                frame_error_n = 1'b1;
                state_n       = IDLE;
            end else begin
                to_cnt_n = to_cnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (byte_valid && byte_data == SOF_BYTE) begin
                    csum_n   = 8'h00;
                    to_cnt_n = '0;
                    state_n  = CMD;
                end
            end
            CMD: begin
                if (byte_valid) begin
                    code_sh_n  = byte_data;
                    csum_n     = byte_data;
                    byte_cnt_n = '0;
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (byte_valid) begin
                    data_sh_n  = {data_sh[DW-9:0], byte_data};
                    csum_n     = csum ^ byte_data;
                    byte_cnt_n = byte_cnt + 1'b1;
                    if (byte_cnt == LAST_IDX) state_n = CSUM;
                end
            end
            CSUM: begin
                if (byte_valid) begin
                    if (byte_data == csum) begin
                        cmd_code_n  = code_sh;
                        cmd_data_n  = data_sh;
                        cmd_valid_n = 1'b1;
                        tx_byte_n   = ACK_BYTE;
                    end else begin
                        frame_error_n = 1'b1;
                        tx_byte_n     = NAK_BYTE;
                    end
                    // The start pulse is registered, so it is high while in RESP_START.
                    tx_start_n = 1'b1;
                    state_n    = RESP_START;
                end
            end
            RESP_START: state_n = RESP_WAIT;
            RESP_WAIT: begin
                if (uart_tx_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: table-driven frames, hand-written corner sequences and
// randomized frames scored against a frame-level model of the protocol.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int         TIMEOUT = 65000;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  logic        clk = 1'b0;
  logic        uart_reset;
  logic        dataAvailable;
  logic [7:0]  receivedData;
  logic        readFlag;
  logic [7:0]  dataToSend;
  logic        uart_tx_start;
  logic        uart_tx_done;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        frame_error;
  logic        busy;
  logic [2:0]  fsm_state;

  uart_cmd_parser #(
    .SOF_BYTE(SOF), .ACK_BYTE(ACK), .NAK_BYTE(NAK),
    .DATA_BYTES(4), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .uart_reset(uart_reset),
    .dataAvailable(dataAvailable), .receivedData(receivedData), .readFlag(readFlag),
    .dataToSend(dataToSend), .uart_tx_start(uart_tx_start), .uart_tx_done(uart_tx_done),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_data(cmd_data),
    .frame_error(frame_error), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rf_cnt   = 0;
  int          err_cnt  = 0;
  int          err_exp  = 0;
  bit          auto_done = 1'b1;
  int          tx_lat    = 2;
  logic [39:0] exp_cmd_q[$];
  logic [7:0]  exp_resp_q[$];
  logic [39:0] last_good = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] frame_xor(input logic [7:0] code, input logic [31:0] data);
    return code ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction

  // Output monitor: every strobe is matched against the expected queues.
  always @(negedge clk) begin
    if (readFlag) rf_cnt++;
    if (frame_error) err_cnt++;
    if (cmd_valid) begin
      if (exp_cmd_q.size() == 0) check("unexpected_cmd_valid", 1, 0);
      else check("cmd_value", {cmd_code, cmd_data}, exp_cmd_q.pop_front());
    end
    if (uart_tx_start) begin
      if (exp_resp_q.size() == 0) check("unexpected_tx_start", 1, 0);
      else check("resp_byte", dataToSend, exp_resp_q.pop_front());
    end
  end

  // Transmitter model: answers each start with a done pulse after tx_lat cycles.
  initial begin
    uart_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_tx_start && auto_done) begin
        repeat (tx_lat) @(negedge clk);
        uart_tx_done = 1'b1;
        @(negedge clk);
        uart_tx_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int hold);
    int waited = 0;
    dataAvailable = 1'b1;
    receivedData  = b;
    do begin
      @(negedge clk);
      waited++;
    end while (!readFlag && waited < 50);
    check("read_latency", waited, 1);
    while (waited < hold) begin
      @(negedge clk);
      waited++;
    end
    dataAvailable = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic [31:0] data,
                            input logic [7:0] csum, input int hold, input bit with_sof);
    if (with_sof) send_byte(SOF, hold);
    send_byte(code, hold);
    for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8], hold);
    send_byte(csum, hold);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic finish_frame(input int exp_rf);
    check("read_count", rf_cnt, exp_rf);
    check("frame_errors", err_cnt, err_exp);
    check("cmd_pending", exp_cmd_q.size(), 0);
    check("resp_pending", exp_resp_q.size(), 0);
    check("held_cmd", {cmd_code, cmd_data}, last_good);
  endtask

  task automatic expect_frame(input logic [7:0] code, input logic [31:0] data,
                              input bit good, input logic [7:0] resp);
    if (good) begin
      exp_cmd_q.push_back({code, data});
      last_good = {code, data};
    end else begin
      err_exp++;
    end
    exp_resp_q.push_back(resp);
  endtask

  task automatic run_frame(input logic [7:0] code, input logic [31:0] data, input logic [7:0] csum,
                           input int hold, input int garb, input bit good, input logic [7:0] resp);
    int rf0 = rf_cnt;
    logic [7:0] g;
    for (int i = 0; i < garb; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == SOF) g = 8'h00;
      send_byte(g, hold);
    end
    expect_frame(code, data, good, resp);
    send_frame(code, data, csum, hold, 1'b1);
    wait_idle();
    finish_frame(rf0 + garb + 7);
  endtask

  typedef struct {
    logic [7:0]  code;
    logic [31:0] data;
    logic [7:0]  csum;
    int          hold;
    bit          good;
    logic [7:0]  resp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #20_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int          n, rf0;
    logic [7:0]  c, cs;
    logic [31:0] d;
    bit          good;

    tbl[0] = '{8'h01, 32'h12345678, 8'h09, 1,  1'b1, ACK};
    tbl[1] = '{8'h01, 32'h12345678, 8'h00, 1,  1'b0, NAK};
    tbl[2] = '{8'h01, 32'h12345678, 8'h09, 20, 1'b1, ACK};
    tbl[3] = '{8'hA5, 32'hA5A5A5A5, 8'hA5, 1,  1'b1, ACK};
    tbl[4] = '{8'h00, 32'h00000000, 8'h00, 2,  1'b1, ACK};
    tbl[5] = '{8'hFF, 32'hFFFFFFFF, 8'hFF, 3,  1'b1, ACK};
    tbl[6] = '{8'h7E, 32'hDEADBEEF, 8'h5C, 1,  1'b1, ACK};
    tbl[7] = '{8'h7E, 32'hDEADBEEF, 8'h5D, 1,  1'b0, NAK};

    // ---- clock / reset ----
    uart_reset    = 1'b1;
    dataAvailable = 1'b0;
    receivedData  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_readFlag", readFlag, 0);
    check("rst_tx_start", uart_tx_start, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_busy", busy, 0);
    check("rst_dataToSend", dataToSend, 0);
    check("rst_cmd_code", cmd_code, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_state", fsm_state, IDLE);
    uart_reset = 1'b0;
    @(negedge clk);

    // ---- table-driven frames ----
    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].code, tbl[i].data, tbl[i].csum, tbl[i].hold, 0, tbl[i].good, tbl[i].resp);

    // ---- leading garbage then a good frame ----
    rf0 = rf_cnt;
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h3C, 1);
    check("garbage_busy", busy, 0);
    run_frame(8'h01, 32'h12345678, 8'h09, 1, 0, 1'b1, ACK);
    check("garbage_read_count", rf_cnt, rf0 + 10);

    // ---- done coincident with start is ignored; bytes wait during response ----
    auto_done = 1'b0;
    rf0 = rf_cnt;
    expect_frame(8'h01, 32'h12345678, 1'b1, ACK);
    send_frame(8'h01, 32'h12345678, 8'h09, 1, 1'b1);
    n = 0;
    while (!uart_tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", uart_tx_start, 1);
    uart_tx_done  = 1'b1;
    dataAvailable = 1'b1;
    receivedData  = SOF;
    @(negedge clk);
    uart_tx_done = 1'b0;
    repeat (6) @(negedge clk);
    check("done_with_start_ignored", busy, 1);
    check("no_read_during_resp", rf_cnt, rf0 + 7);
    uart_tx_done = 1'b1;
    @(negedge clk);
    uart_tx_done = 1'b0;
    n = 0;
    while (!readFlag && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("held_byte_read_after_resp", readFlag, 1);
    dataAvailable = 1'b0;
    @(negedge clk);
    auto_done = 1'b1;
    expect_frame(8'h42, 32'h0BADF00D, 1'b1, ACK);
    send_frame(8'h42, 32'h0BADF00D, frame_xor(8'h42, 32'h0BADF00D), 1, 1'b0);
    wait_idle();
    finish_frame(rf0 + 14);

    // ---- inter-byte timeout ----
    rf0 = rf_cnt;
    send_byte(SOF, 1);
    send_byte(8'h01, 1);
    send_byte(8'h12, 1);
    n = 1;
    while (!frame_error && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_error", frame_error, 1);
    check("timeout_window", (n >= TIMEOUT) && (n <= TIMEOUT + 3), 1);
    check("timeout_state", fsm_state, IDLE);
    check("timeout_busy", busy, 0);
    err_exp++;
    repeat (4) @(negedge clk);
    finish_frame(rf0 + 3);
    run_frame(8'h01, 32'h12345678, 8'h09, 1, 0, 1'b1, ACK);

    // ---- reset in the middle of a frame ----
    send_byte(SOF, 1);
    send_byte(8'h01, 1);
    send_byte(8'h34, 1);
    uart_reset = 1'b1;
    @(negedge clk);
    check("midrst_readFlag", readFlag, 0);
    check("midrst_tx_start", uart_tx_start, 0);
    check("midrst_cmd_valid", cmd_valid, 0);
    check("midrst_frame_error", frame_error, 0);
    check("midrst_busy", busy, 0);
    check("midrst_dataToSend", dataToSend, 0);
    check("midrst_cmd", {cmd_code, cmd_data}, 0);
    check("midrst_state", fsm_state, IDLE);
    uart_reset = 1'b0;
    last_good  = '0;
    @(negedge clk);
    run_frame(8'h01, 32'h12345678, 8'h09, 1, 0, 1'b1, ACK);

    // ---- randomized frames against the frame-level model ----
    for (int k = 0; k < 25; k++) begin
      c      = 8'($urandom_range(0, 255));
      d      = $urandom;
      good   = ($urandom_range(0, 9) < 7);
      cs     = good ? frame_xor(c, d) : (frame_xor(c, d) ^ 8'($urandom_range(1, 255)));
      tx_lat = $urandom_range(1, 6);
      run_frame(c, d, cs, $urandom_range(1, 4), $urandom_range(0, 2), good, good ? ACK : NAK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
